// File: rtl/ir_key_event.sv
// NEC IR frame post-processor: validates complement bytes, optionally filters
// on address, and turns raw frames into key press / hold / release events.
module ir_key_event #(
  parameter int unsigned HOLD_CYC       = 6000000,
  parameter bit          STRICT_ADDR    = 1'b0,
  parameter bit          ADDR_FILTER_EN = 1'b0,
  parameter logic [7:0]  ADDR_MATCH     = 8'h86,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic [31:0]      frame_data,
  output logic             key_valid,
  output logic [7:0]       key_addr,
  output logic [7:0]       key_cmd,
  output logic             key_held,
  output logic             key_release,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      last_frame
);

  localparam int unsigned   TW     = $clog2(HOLD_CYC) + 1;
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYC - 1);

  typedef enum logic {S_IDLE, S_HELD} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_fv_s;
  logic          r_fv_hist;
  logic [31:0]   r_data_s;
  logic [31:0]   r_frame;
  logic          r_chk;

  logic w_new, w_cmd_ok, w_addr_ok, w_filt_ok, w_acc, w_rej, w_same;

  always_comb begin
    w_new     = r_fv_s && !r_fv_hist;
    w_cmd_ok  = (r_frame[31:24] == ~r_frame[23:16]);
    w_addr_ok = !STRICT_ADDR || (r_frame[15:8] == ~r_frame[7:0]);
    w_filt_ok = !ADDR_FILTER_EN || (r_frame[7:0] == ADDR_MATCH);
    w_acc     = r_chk && w_cmd_ok && w_addr_ok && w_filt_ok;
    w_rej     = r_chk && !(w_cmd_ok && w_addr_ok && w_filt_ok);
    w_same    = (r_frame[23:16] == key_cmd) && (r_frame[7:0] == key_addr);
  end

  // Input sample, then edge-detect/capture, then evaluate: event outputs
  // appear two clocks after the clock that samples the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fv_s      <= 1'b0;
      r_fv_hist   <= 1'b0;
      r_data_s    <= '0;
      r_frame     <= '0;
      r_chk       <= 1'b0;
      r_state     <= S_IDLE;
      r_timer     <= '0;
      key_valid   <= 1'b0;
      key_addr    <= '0;
      key_cmd     <= '0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      last_frame  <= '0;
    end else begin
      r_fv_s      <= frame_valid;
      r_data_s    <= frame_data;
      r_fv_hist   <= r_fv_s;
      r_chk       <= w_new;
      if (w_new) r_frame <= r_data_s;

      key_valid   <= 1'b0;
      key_release <= 1'b0;
      err_pulse   <= 1'b0;

      if (w_rej) begin
        err_pulse <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end

      if (w_acc) last_frame <= r_frame;

      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            key_valid <= 1'b1;
            key_addr  <= r_frame[7:0];
            key_cmd   <= r_frame[23:16];
            key_held  <= 1'b1;
            r_timer   <= RELOAD;
            r_state   <= S_HELD;
          end
        end
        S_HELD: begin
          // An accepted frame beats an expiring timer in the same cycle.
          if (w_acc) begin
            r_timer <= RELOAD;
            if (!w_same) begin
              key_valid <= 1'b1;
              key_addr  <= r_frame[7:0];
              key_cmd   <= r_frame[23:16];
            end
          end else if (r_timer == '0) begin
            key_release <= 1'b1;
            key_held    <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_key_event.sv
// Directed bench for ir_key_event: expected key/release/error events are queued
// with their due cycle when stimulus is driven and matched as the DUT emits them.
module tb_ir_key_event;

  localparam logic [31:0] F   = 32'hED12_7986;
  localparam logic [31:0] F13 = 32'hEC13_7986;
  localparam logic [31:0] BAD = 32'hEE12_7986;
  localparam logic [31:0] XA  = 32'hED12_0086;

  localparam int EV_KV  = 0;
  localparam int EV_REL = 1;
  localparam int EV_ERR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        frame_valid;
  logic [31:0] frame_data;

  logic        m_kv, m_held, m_rel, m_err;
  logic [7:0]  m_addr, m_cmd, m_ecnt;
  logic [31:0] m_last;
  logic        f_kv, f_held, f_rel, f_err;
  logic [7:0]  f_addr, f_cmd, f_ecnt;
  logic [31:0] f_last;
  logic        s_kv, s_held, s_rel, s_err;
  logic [7:0]  s_addr, s_cmd, s_ecnt;
  logic [31:0] s_last;

  ir_key_event #(.HOLD_CYC(100)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .key_valid(m_kv), .key_addr(m_addr), .key_cmd(m_cmd), .key_held(m_held),
    .key_release(m_rel), .err_pulse(m_err), .err_count(m_ecnt), .last_frame(m_last));

  ir_key_event #(.HOLD_CYC(100), .ADDR_FILTER_EN(1'b1), .ADDR_MATCH(8'h55)) dut_filt (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .key_valid(f_kv), .key_addr(f_addr), .key_cmd(f_cmd), .key_held(f_held),
    .key_release(f_rel), .err_pulse(f_err), .err_count(f_ecnt), .last_frame(f_last));

  ir_key_event #(.HOLD_CYC(100), .STRICT_ADDR(1'b1)) dut_strict (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .key_valid(s_kv), .key_addr(s_addr), .key_cmd(s_cmd), .key_held(s_held),
    .key_release(s_rel), .err_pulse(s_err), .err_count(s_ecnt), .last_frame(s_last));

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] addr;
    logic [7:0] cmd;
  } ev_t;

  ev_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  f_kv_n = 0, f_err_n = 0, s_kv_n = 0, s_err_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [7:0] a, input logic [7:0] cm);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.cmd = cm;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_event_kind%0d_at_%0d", kind, cyc), exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check($sformatf("event_cycle_kind%0d", kind), cyc, e.cyc);
      if (kind == EV_KV) begin
        check("ev_key_addr", m_addr, e.addr);
        check("ev_key_cmd", m_cmd, e.cmd);
      end
      if (kind == EV_REL) begin
        check("rel_kv_exclusive", m_kv, 0);
        check("held_low_on_release", m_held, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_kv)  take(EV_KV);
    if (m_rel) take(EV_REL);
    if (m_err) take(EV_ERR);
    if (f_kv)  f_kv_n++;
    if (f_err) f_err_n++;
    if (s_kv)  s_kv_n++;
    if (s_err) s_err_n++;
  end

  // Drive a one-cycle frame_valid pulse from a negedge; cd is the cycle count
  // at the drive point, so stage-2 outputs are seen at cycle cd+3.
  task automatic pulse(input logic [31:0] d, output int cd);
    frame_data  = d;
    frame_valid = 1'b1;
    cd          = cyc;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  initial begin
    int cd, cd2, fk, fe, sk, se;
    rst = 1'b1; frame_valid = 1'b0; frame_data = '0;
    repeat (3) @(negedge clk);
    check("rst_key_valid", m_kv, 0);
    check("rst_key_held", m_held, 0);
    check("rst_key_release", m_rel, 0);
    check("rst_err_pulse", m_err, 0);
    check("rst_err_count", m_ecnt, 0);
    check("rst_last_frame", m_last, 0);
    check("rst_key_addr", m_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single press, then release after the hold time.
    pulse(F, cd);
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    push(EV_REL, cd + 103, 8'h86, 8'h12);
    repeat (3) @(negedge clk);
    check("p1_key_addr", m_addr, 8'h86);
    check("p1_key_cmd", m_cmd, 8'h12);
    check("p1_key_held", m_held, 1);
    check("p1_last_frame", m_last, F);
    check("p1_err_count", m_ecnt, 0);
    repeat (105) @(negedge clk);
    check("p1_held_after_rel", m_held, 0);

    // Auto-repeat of the same key 60 clocks later.
    pulse(F, cd);
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    repeat (59) @(negedge clk);
    pulse(F, cd2);
    push(EV_REL, cd2 + 103, 8'h86, 8'h12);
    repeat (50) @(negedge clk);
    check("rep_held_mid", m_held, 1);
    repeat (60) @(negedge clk);
    check("rep_held_after_rel", m_held, 0);

    // Different key while held.
    pulse(F, cd);
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    repeat (29) @(negedge clk);
    pulse(F13, cd2);
    push(EV_KV, cd2 + 3, 8'h86, 8'h13);
    push(EV_REL, cd2 + 103, 8'h86, 8'h13);
    repeat (3) @(negedge clk);
    check("chg_key_cmd", m_cmd, 8'h13);
    check("chg_key_held", m_held, 1);
    check("chg_last_frame", m_last, F13);
    repeat (110) @(negedge clk);

    // Bad frame, then saturation of the error counter.
    pulse(BAD, cd);
    push(EV_ERR, cd + 3, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("bad_err_count", m_ecnt, 1);
    check("bad_last_frame", m_last, F13);
    check("bad_key_held", m_held, 0);
    for (int i = 0; i < 260; i++) begin
      pulse(BAD, cd);
      push(EV_ERR, cd + 3, 8'h00, 8'h00);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("sat_err_count", m_ecnt, 8'hFF);
    check("sat_last_frame", m_last, F13);

    // Level held high yields a single frame.
    frame_data = F; frame_valid = 1'b1; cd = cyc;
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    push(EV_REL, cd + 103, 8'h86, 8'h12);
    repeat (500) @(negedge clk);
    frame_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("lvl_key_held", m_held, 0);

    // Address filter and strict-address variants.
    fk = f_kv_n; fe = f_err_n; sk = s_kv_n; se = s_err_n;
    pulse(F, cd);
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    push(EV_REL, cd + 103, 8'h86, 8'h12);
    repeat (110) @(negedge clk);
    check("filt_err_pulses", f_err_n - fe, 1);
    check("filt_kv_pulses", f_kv_n - fk, 0);
    check("strict_good_kv", s_kv_n - sk, 1);
    check("strict_good_err", s_err_n - se, 0);
    sk = s_kv_n; se = s_err_n;
    pulse(XA, cd);
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    push(EV_REL, cd + 103, 8'h86, 8'h12);
    repeat (110) @(negedge clk);
    check("strict_bad_err", s_err_n - se, 1);
    check("strict_bad_kv", s_kv_n - sk, 0);
    check("ext_last_frame", m_last, XA);

    // Accepted frame on the timer==0 cycle suppresses release.
    pulse(F, cd);
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    repeat (99) @(negedge clk);
    pulse(F, cd2);
    push(EV_REL, cd2 + 103, 8'h86, 8'h12);
    repeat (3) @(negedge clk);
    check("t0_key_held", m_held, 1);
    repeat (110) @(negedge clk);
    check("t0_held_after_rel", m_held, 0);

    // Reset while held: clean drop with no release pulse.
    pulse(F, cd);
    push(EV_KV, cd + 3, 8'h86, 8'h12);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_key_held", m_held, 0);
    check("mid_rst_key_addr", m_addr, 0);
    check("mid_rst_key_cmd", m_cmd, 0);
    check("mid_rst_last_frame", m_last, 0);
    check("mid_rst_err_count", m_ecnt, 0);
    check("mid_rst_key_release", m_rel, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);

    check("events_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_key_event.md
Name: ir_key_event

Overview:
- Post-processing stage directly downstream of the NEC IR receiver.
- Consumes the receiver's 32-bit decoded frame and its ready flag.
- Validates the NEC complement bytes, optionally filters on address, and turns raw frames into clean key press, hold and release events.
- Also keeps the last good frame for the HEX display path and counts corrupt frames.

Parameters:
- HOLD_CYC, 6000000, clocks a key stays "held" after its last accepted frame (120 ms at 50 MHz; covers the 108 ms NEC repeat spacing).
- STRICT_ADDR, 0, 1 = also require frame[15:8] == ~frame[7:0]; 0 = extended NEC, address complement ignored.
- ADDR_FILTER_EN, 0, 1 = reject frames whose frame[7:0] != ADDR_MATCH.
- ADDR_MATCH, 8'h86, address accepted when filtering is enabled.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- frame_valid  in  1  receiver data_ready; may be a pulse or a level; only its rising edge is used
- frame_data  in  32  {~cmd[31:24], cmd[23:16], ~addr[15:8], addr[7:0]}
- key_valid  out  1  one-cycle pulse: new key press, or a different key while held
- key_addr  out  8  address of the current key
- key_cmd  out  8  command of the current key
- key_held  out  1  high while the hold timer is running
- key_release  out  1  one-cycle pulse when the hold timer expires
- err_pulse  out  1  one-cycle pulse per rejected frame
- err_count  out  ERR_W  saturating count of rejected frames
- last_frame  out  32  last accepted 32-bit frame, for the HEX display

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, edge-detect history register 0. Reset applies mid-operation: it drops key_held with no key_release pulse.
- Edge detect: a new frame is frame_valid==1 with the previous sample ==0. A level held high yields one frame only.
- Stage 1: on a new frame, register frame_data and set the check flag.
- Stage 2: evaluate the registered frame and drive outputs.
- Latency: key_valid or err_pulse is high exactly 2 clocks after the clock that samples the rising edge of frame_valid.
- Accept rule: frame[31:24] == ~frame[23:16], AND (STRICT_ADDR==0 or frame[15:8] == ~frame[7:0]), AND (ADDR_FILTER_EN==0 or frame[7:0] == ADDR_MATCH).
- Rejected frame:
  - err_pulse for 1 cycle.
  - err_count += 1; it saturates at all-ones and does not wrap.
  - State, timer, key_* and last_frame are unchanged.
- Accepted frame:
  - last_frame <= frame.
  - Timer <= HOLD_CYC-1.
  - Then act per the state machine below.
- FSM IDLE:
  - Accepted frame -> key_valid=1, key_addr/key_cmd loaded, key_held=1, go to HELD.
- FSM HELD:
  - Accepted frame with the same addr+cmd: auto-repeat; reload timer, no key_valid, stay in HELD.
  - Accepted frame with a different addr or cmd: key_valid=1, new key_addr/key_cmd, reload timer, stay in HELD, no key_release.
  - Timer == 0 with no accepted frame this cycle: key_release=1, key_held=0, go to IDLE. key_addr/key_cmd keep their last values.
  - Otherwise the timer decrements by 1 each clock.
- Simultaneous events:
  - Accepted frame in the same cycle as timer == 0: the frame wins; reload the timer, no key_release.
  - Rejected frame in the same cycle as timer == 0: release proceeds and err_pulse is also asserted.
- Timer width: clog2(HOLD_CYC)+1 bits. HOLD_CYC >= 2 is required.
- key_valid, key_release and err_pulse are never high for more than 1 consecutive cycle.
- key_valid and key_release are never high in the same cycle.

Test Plan (HOLD_CYC=100 for simulation; frame F = 32'hED12_7986, i.e. addr 86, cmd 12):
- Reset, then a 1-cycle frame_valid pulse with F -> key_valid pulse 2 clocks later; key_addr=86, key_cmd=12, key_held=1, last_frame=ED127986, err_count=0.
- F, then F again 60 clocks later -> one key_valid only; key_release pulse exactly 100 clocks after the second frame's accept cycle; key_held=0 after it.
- F held, then 32'hEC13_7986 (cmd 13) -> second key_valid, key_cmd=13, no key_release in between; release 100 clocks later.
- Bad frame 32'hEE12_7986 -> err_pulse, err_count=1, last_frame unchanged. Force err_count to 255 and send another bad frame -> count stays 255.
- frame_valid held high for 500 clocks with F -> exactly one key_valid.
- ADDR_FILTER_EN=1, ADDR_MATCH=8'h55, send F -> err_pulse and no key_valid.
- STRICT_ADDR=1 with 32'hED12_0086 -> rejected.
- Frame accepted on the timer==0 cycle -> no key_release; key_held stays 1.
- Assert rst while HELD -> all outputs 0 on the next clock; no key_release pulse.
